// File: rtl/div32_rv32m_ctrl.sv
// RV32M DIV/DIVU/REM/REMU controller around a single combinational unsigned divider.
// Operands are captured as magnitudes; the sign fix-up is applied when the result is registered.
module div32_rv32m_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_rem_q, op_rem_d;
   logic        neg_q, neg_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;

   logic        accept;
   logic        is_signed;
   logic        sign_a, sign_b;
   logic        div_zero, sgn_ovf;
   logic [31:0] mag_a, mag_b;
   logic [31:0] div_quot, div_rem, raw_res;

   // The divider only ever sees registered magnitudes, so it is free of input-side glitches.
   always_comb begin
      div_quot = a_q / b_q;
      div_rem  = a_q % b_q;
      raw_res  = op_rem_q ? div_rem : div_quot;
   end

   always_comb begin
      accept    = in_valid && (state_q == S_IDLE);
      is_signed = ~in_op[0];
      sign_a    = is_signed & in_a[31];
      sign_b    = is_signed & in_b[31];
      mag_a     = sign_a ? (~in_a + 32'd1) : in_a;
      mag_b     = sign_b ? (~in_b + 32'd1) : in_b;
      div_zero  = (in_b == '0);
      sgn_ovf   = is_signed && (in_a == 32'h8000_0000) && (in_b == '1);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_rem_d = op_rem_q;
      neg_d    = neg_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_rem_d = in_op[1];
               // REM follows the dividend's sign; DIV negates on differing signs.
               neg_d    = in_op[1] ? sign_a : (sign_a ^ sign_b);
               a_d      = mag_a;
               b_d      = mag_b;
               if (div_zero) begin
                  res_d   = in_op[1] ? in_a : '1;
                  state_d = S_DONE;
               end else if (sgn_ovf) begin
                  res_d   = in_op[1] ? '0 : 32'h8000_0000;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = 4'(SETTLE_CYCLES - 1);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (cnt_q == '0) begin
               res_d   = neg_q ? (~raw_res + 32'd1) : raw_res;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_rem_q <= 1'b0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_rem_q <= op_rem_d;
         neg_q    <= neg_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_res   = res_q;

endmodule

// File: tb/tb_div32_rv32m_ctrl.sv
// Randomized self-checking bench for div32_rv32m_ctrl against an arithmetic RV32M model.
module tb_div32_rv32m_ctrl;

   localparam int unsigned SETTLE = 2;
   localparam int unsigned MAX_WAIT = 40;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic        busy;

   int unsigned n_checks;
   int unsigned n_fails;

   div32_rv32m_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RV32M semantics straight from the ISA rules using native signed/unsigned arithmetic.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return 32'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   // Issue one request, check latency, hold in DONE for 'hold' cycles, then deliver.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned hold);
      logic [31:0] exp;
      int unsigned lat;
      int unsigned exp_lat;
      exp     = model(op, a, b);
      exp_lat = is_special(op, a, b) ? 1 : SETTLE + 1;
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_op    = 2'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      lat = 1;
      forever begin
         @(negedge clk);
         if (out_valid || lat > MAX_WAIT) break;
         @(posedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, out_res, exp);
      for (int unsigned i = 0; i < hold; i++) begin
         in_a     = $urandom;
         in_valid = 1'b1;
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_res"}, out_res, exp);
         check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_res"}, out_res, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      n_checks  = 0;
      n_fails   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("div_neg7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("rem_neg7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 1);
      do_op("divu_100_7",  2'b01, 32'd100, 32'd7, 0);
      do_op("remu_100_7",  2'b11, 32'd100, 32'd7, 0);
      do_op("divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1, 0);
      do_op("div_5_0",     2'b00, 32'd5, 32'd0, 0);
      do_op("remu_5_0",    2'b11, 32'd5, 32'd0, 0);
      do_op("divu_5_0",    2'b01, 32'd5, 32'd0, 0);
      do_op("rem_neg5_0",  2'b10, 32'hFFFF_FFFB, 32'd0, 0);
      do_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("div_min_2",   2'b00, 32'h8000_0000, 32'd2, 0);
      do_op("rem_7_neg2",  2'b10, 32'd7, 32'hFFFF_FFFE, 0);
      do_op("div_neg_neg", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0);
      do_op("hold5",       2'b00, 32'd1000, 32'hFFFF_FFFD, 5);

      for (int unsigned n = 0; n < 200; n++) begin
         r_op = 2'($urandom);
         r_a  = $urandom;
         case ($urandom_range(0, 9))
            0:       r_b = 32'd0;
            1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            2:       r_b = 32'($urandom_range(1, 16));
            3:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 16));
            default: r_b = $urandom;
         endcase
         do_op("rand", r_op, r_a, r_b, $urandom_range(0, 3));
      end

      // Reset during CALC discards the operation.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_a     = 32'd1000;
      in_b     = 32'd10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("calc_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_calc");
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_calc_no_valid", {31'd0, out_valid}, 32'd0);
         check("rst_calc_ready", {31'd0, in_ready}, 32'd1);
      end
      do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

      // Reset while DONE is held discards the pending result.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 32'd5;
      in_b     = 32'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("done_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_done");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_done_no_valid", {31'd0, out_valid}, 32'd0);
      do_op("after_rst_done", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
